// File: rtl/wallace_mult_pipe.sv
// -----------------------------------------------------------------------------
// wallace_mult_pipe
//
// Pipelined WIDTH x WIDTH Wallace-tree multiplier with a valid/ready stream
// interface and a per-transaction signed/unsigned mode.
//
//   S1: registers in_a, in_b, in_signed
//   S2: registers the two rows (sum / carry) left by the Wallace reduction of
//       the S1 partial products (Baugh-Wooley in signed mode)
//   S3: registers the ripple-carry sum of the S2 rows into out_p
//
// All ranks move together on adv = !v3 | out_ready, so a stalled output
// freezes the whole pipe while empty output slots let bubbles collapse.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operands valid            in_ready   operands accepted (= adv)
//   in_a       multiplicand (WIDTH)      in_b       multiplier (WIDTH)
//   in_signed  1: two's complement operands, 0: unsigned
//   out_valid  out_p holds a product     out_ready  consumer accepts product
//   out_p      product, 2*WIDTH bits, modulo 2^(2*WIDTH)
// -----------------------------------------------------------------------------
module wallace_mult_pipe #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]   in_b,
   input  logic               in_signed,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] out_p
);

   localparam int PW     = 2 * WIDTH;  // product / column count
   localparam int H      = WIDTH + 4;  // column height bound, with margin for incoming carries
   localparam int LAYERS = 16;         // enough 3:2 layers to bring WIDTH+1 rows down to 2 for WIDTH<=32

   // Builds the partial-product columns and reduces them with layers of full
   // and half adders until every column holds at most two bits. Returns
   // {carry_row, sum_row}. Everything indexed by cnt[] is fixed by WIDTH, so
   // the loops unroll into a static adder tree.
   function automatic logic [2*PW-1:0] wallace_rows(
      input logic [WIDTH-1:0] a,
      input logic [WIDTH-1:0] b,
      input logic             sgn
   );
      logic [H-1:0]  col  [PW];
      logic [H-1:0]  nxt  [PW];
      int            cnt  [PW];
      int            ncnt [PW];
      logic [PW-1:0] row0;
      logic [PW-1:0] row1;
      logic          x, y, z, s, c;
      int            rem;

      for (int k = 0; k < PW; k++) begin
         col[k] = '0;
         cnt[k] = 0;
      end

      // AND array; in signed mode, bits that pair exactly one operand MSB with
      // a non-MSB bit are inverted (Baugh-Wooley).
      for (int i = 0; i < WIDTH; i++) begin
         for (int j = 0; j < WIDTH; j++) begin
            x = a[j] & b[i];
            if (sgn && ((i == WIDTH-1) != (j == WIDTH-1))) x = ~x;
            col[i+j][cnt[i+j]] = x;
            cnt[i+j]++;
         end
      end

      // Baugh-Wooley correction constants, present only in signed mode.
      col[WIDTH][cnt[WIDTH]] = sgn;
      cnt[WIDTH]++;
      col[PW-1][cnt[PW-1]] = sgn;
      cnt[PW-1]++;

      for (int l = 0; l < LAYERS; l++) begin
         for (int k = 0; k < PW; k++) begin
            nxt[k]  = '0;
            ncnt[k] = 0;
         end
         for (int k = 0; k < PW; k++) begin
            if (cnt[k] < 3) begin
               // Short columns pass straight through to the next layer.
               for (int m = 0; m < 3; m++) begin
                  if (m < cnt[k] && ncnt[k] < H) begin
                     nxt[k][ncnt[k]] = col[k][m];
                     ncnt[k]++;
                  end
               end
            end else begin
               for (int g = 0; g < H/3; g++) begin
                  if (3*g + 3 <= cnt[k]) begin
                     x = col[k][3*g];
                     y = col[k][3*g+1];
                     z = col[k][3*g+2];
                     s = x ^ y ^ z;
                     c = (x & y) | (x & z) | (y & z);
                     if (ncnt[k] < H) begin
                        nxt[k][ncnt[k]] = s;
                        ncnt[k]++;
                     end
                     // Carries leaving the top column fall off: result is mod 2^PW.
                     if (k < PW-1) begin
                        if (ncnt[k+1] < H) begin
                           nxt[k+1][ncnt[k+1]] = c;
                           ncnt[k+1]++;
                        end
                     end
                  end
               end
               rem = cnt[k] - 3 * (cnt[k] / 3);
               if (rem == 2) begin
                  x = col[k][cnt[k]-2];
                  y = col[k][cnt[k]-1];
                  if (ncnt[k] < H) begin
                     nxt[k][ncnt[k]] = x ^ y;
                     ncnt[k]++;
                  end
                  if (k < PW-1) begin
                     if (ncnt[k+1] < H) begin
                        nxt[k+1][ncnt[k+1]] = x & y;
                        ncnt[k+1]++;
                     end
                  end
               end else if (rem == 1) begin
                  if (ncnt[k] < H) begin
                     nxt[k][ncnt[k]] = col[k][cnt[k]-1];
                     ncnt[k]++;
                  end
               end
            end
         end
         for (int k = 0; k < PW; k++) begin
            col[k] = nxt[k];
            cnt[k] = ncnt[k];
         end
      end

      for (int k = 0; k < PW; k++) begin
         row0[k] = (cnt[k] > 0) ? col[k][0] : 1'b0;
         row1[k] = (cnt[k] > 1) ? col[k][1] : 1'b0;
      end
      return {row1, row0};
   endfunction

   // Ripple-carry adder; the final carry-out is dropped.
   function automatic logic [PW-1:0] ripple_add(
      input logic [PW-1:0] x,
      input logic [PW-1:0] y
   );
      logic [PW-1:0] sum;
      logic          cy;
      cy = 1'b0;
      for (int k = 0; k < PW; k++) begin
         sum[k] = x[k] ^ y[k] ^ cy;
         cy     = (x[k] & y[k]) | (cy & (x[k] ^ y[k]));
      end
      return sum;
   endfunction

   // Pipeline state
   logic             v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic             sgn_q, sgn_d;
   logic [PW-1:0]    rs_q, rs_d, rc_q, rc_d;
   logic [PW-1:0]    p_q, p_d;
   logic             adv;

   // NOTE: every signal assigned in always_comb gets a value on every path
   // (here via the hold branch of each ternary), otherwise a latch is inferred.
   always_comb begin
      adv      = !v3_q | out_ready;
      in_ready = adv;

      v1_d  = adv ? in_valid : v1_q;
      v2_d  = adv ? v1_q     : v2_q;
      v3_d  = adv ? v2_q     : v3_q;

      a_d   = adv ? in_a      : a_q;
      b_d   = adv ? in_b      : b_q;
      sgn_d = adv ? in_signed : sgn_q;

      {rc_d, rs_d} = adv ? wallace_rows(a_q, b_q, sgn_q) : {rc_q, rs_q};

      p_d   = adv ? ripple_add(rs_q, rc_q) : p_q;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge value of its neighbours regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q  <= 1'b0;
         v2_q  <= 1'b0;
         v3_q  <= 1'b0;
         a_q   <= '0;
         b_q   <= '0;
         sgn_q <= 1'b0;
         rs_q  <= '0;
         rc_q  <= '0;
         p_q   <= '0;
      end else begin
         v1_q  <= v1_d;
         v2_q  <= v2_d;
         v3_q  <= v3_d;
         a_q   <= a_d;
         b_q   <= b_d;
         sgn_q <= sgn_d;
         rs_q  <= rs_d;
         rc_q  <= rc_d;
         p_q   <= p_d;
      end
   end

   assign out_valid = v3_q;
   assign out_p     = p_q;

endmodule
